triang_mat_inv: RTL and testbench
=================================

// Module: triang_mat_inv
// PURPOSE
//  Inverts a SIZE x SIZE complex upper-triangular matrix (IEEE-754 double parts) held in external row storage.
//  Downstream stage of the LU path: reads rows by address, computes X = A^-1 by back-substitution,
//  and emits X one column per handshake. Used to invert LU factors in turn.
// PARAMETERS
//  SIZE   16  matrix dimension; AW = $clog2(SIZE) (package constant)
//  WIDTH  64  bits per real/imag part (IEEE double)
// PORTS
//  clk_i                 in   1               clock
//  rst_ni                in   1               async active-low reset
//  mat_row_i             in   SIZE x 128      row of A; element k = {imag[127:64], real[63:0]}
//  mat_row_valid_i       in   1               mat_row_i/mat_row_addr_i valid
//  mat_row_addr_i        in   AW              row index of returned data
//  mat_row_addr_o        out  AW              row read request address
//  mat_row_addr_valid_o  out  1               read request valid
//  inv_col_o             out  2*SIZE x 64     column j of X; [2i]=real(X[i][j]), [2i+1]=imag(X[i][j])
//  inv_col_addr_o        out  AW              column index j
//  inv_col_valid_o       out  1               column valid (held until accepted)
//  in_ready_o            out  1               idle, start accepted
//  flush_i               in   1               synchronous abort
//  start                 in   1               begin inversion
//  out_ready_i           in   1               downstream accepts column
//  busy_o                out  1               operation in progress
// BEHAVIOUR
//  - Reset: FSM=IDLE, in_ready_o=1; busy_o, mat_row_addr_valid_o, inv_col_valid_o=0; all data/address outputs 0.
//  - States: IDLE -> LOAD -> CALC -> OUT -> (CALC for next j | IDLE after j=SIZE-1).
//  - IDLE: start && in_ready_o accepted. Next cycle in_ready_o=0, busy_o=1. start while not in IDLE is ignored.
//  - LOAD: issue addresses 0..SIZE-1, one per cycle, mat_row_addr_valid_o=1. Capture mat_row_i into internal
//    row store at mat_row_addr_i whenever mat_row_valid_i; any return latency >=1 accepted. Go to CALC when all rows captured.
//  - Lower triangle of A is ignored (treated as zero).
//  - CALC for column j, i = j down to 0:
//    X[j][j] = 1/A[j][j];
//    X[i][j] = -(sum_{k=i+1..j} A[i][k]*X[k][j]) / A[i][i];  X[i][j] = 0 for i>j.
//    One complex multiply-accumulate per cycle, one complex divide per i; terms summed in increasing k.
//  - Complex mult: (a+jb)(c+jd) = (ac-bd) + j(ad+bc).
//    Complex divide: multiply by conjugate over |d|^2. Double precision throughout.
//  - Zero diagonal: IEEE inf/NaN propagate; no flag.
//  - OUT: inv_col_valid_o=1 with inv_col_o/inv_col_addr_o=j stable until out_ready_i sampled high.
//    Transfer on valid&&ready, then j+1. Columns emitted in order 0..SIZE-1.
//  - Completion: after column SIZE-1 is transferred, next cycle busy_o=0, in_ready_o=1.
//  - flush_i (any state): next cycle IDLE with reset output values. In-flight column dropped, no further valid or read requests.
//    flush_i has priority over start.
//  - rst_ni low mid-operation: immediate return to reset state; row store contents don't care.
// CONFIGURATION
//  - TRIANG_INV_UNIT_DIAG_EN defined: diagonal of A treated as 1+j0 and never read.
//    X[i][i]=1, each divide becomes negation; no divider instanced.
//  - Not defined: full general diagonal as above.
// STRUCTURE
//  - Package triang_inv_pkg: SIZE/AW defaults, cplx_t {logic [63:0] im, re}, FSM state enum.
//  - Sub-module cplx_fp_unit: complex acc-(a*b) and complex divide on cplx_t, 1-cycle registered result.
//    Behavioural real model for simulation; synthesizable replacement keeps the same interface and latency.
// TESTING (SIZE=4)
//  - Identity input -> columns equal unit vectors e_j, addr 0..3 in order, then in_ready_o=1.
//  - diag(2,4,-1,0.5) -> diag(0.5,0.25,-1,2).
//  - Rows [1 2 0 0],[0 1 3 0],[0 0 1 0],[0 0 0 1] -> col2 = (6,-3,1,0), col1 = (-2,1,0,0).
//  - diag(0+j1) -> diag(0-j1); imag sits in odd slots of inv_col_o.
//  - out_ready_i low 10 cycles during column 1 -> valid/data/addr held stable; resumes without loss.
//  - flush_i during CALC -> next cycle in_ready_o=1, busy_o=0, no inv_col_valid_o afterwards.
//  - Re-start after flush runs to completion.

Source files
------------

// File: rtl/triang_inv_pkg.sv
// Shared defaults, complex element type and FSM encoding for the upper-triangular
// complex matrix inverter.
package triang_inv_pkg;

  localparam int DEF_SIZE  = 16;
  localparam int DEF_AW    = $clog2(DEF_SIZE);
  localparam int DEF_WIDTH = 64;

  // Matches the row bus element layout: {imag[127:64], real[63:0]}.
  typedef struct packed {
    logic [63:0] im;
    logic [63:0] re;
  } cplx_t;

  localparam cplx_t CPLX_ZERO = {64'h0, 64'h0};
  localparam cplx_t CPLX_ONE  = {64'h0, 64'h3FF0_0000_0000_0000};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/cplx_fp_unit.sv
// Complex double-precision unit: res = acc - a*b (op_div=0) or res = acc / b (op_div=1),
// registered. TRIANG_INV_UNIT_DIAG_EN drops the divider; the divide op passes acc through.
module cplx_fp_unit
  import triang_inv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         op_valid,
  input  logic         op_div,
  input  logic [127:0] acc,
  input  logic [127:0] a,
  input  logic [127:0] b,
  output logic [127:0] res
);

  cplx_t acc_c, a_c, b_c, mac_c, nxt_c, res_q;
  real   acc_re, acc_im, a_re, a_im, b_re, b_im;
  real   mac_re, mac_im;

  assign acc_c = acc;
  assign a_c   = a;
  assign b_c   = b;

  always_comb begin
    acc_re = $bitstoreal(acc_c.re);
    acc_im = $bitstoreal(acc_c.im);
    a_re   = $bitstoreal(a_c.re);
    a_im   = $bitstoreal(a_c.im);
    b_re   = $bitstoreal(b_c.re);
    b_im   = $bitstoreal(b_c.im);
    mac_re = acc_re - (a_re * b_re - a_im * b_im);
    mac_im = acc_im - (a_re * b_im + a_im * b_re);
    mac_c  = {$realtobits(mac_im), $realtobits(mac_re)};
  end

`ifdef TRIANG_INV_UNIT_DIAG_EN
  always_comb begin
    nxt_c = op_div ? acc_c : mac_c;
  end
`else
  real den, div_re, div_im;

  // Multiply by the conjugate over |b|^2; a zero divisor yields IEEE inf/NaN.
  always_comb begin
    den    = b_re * b_re + b_im * b_im;
    div_re = (acc_re * b_re + acc_im * b_im) / den;
    div_im = (acc_im * b_re - acc_re * b_im) / den;
    nxt_c  = op_div ? {$realtobits(div_im), $realtobits(div_re)} : mac_c;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q <= CPLX_ZERO;
    end else if (op_valid) begin
      res_q <= nxt_c;
    end
  end

  assign res = res_q;

endmodule

// File: rtl/triang_mat_inv.sv
// Inverts a complex upper-triangular matrix by column-wise back-substitution.
// Optional TRIANG_INV_UNIT_DIAG_EN: unit diagonal assumed, diagonal never read.
//
// state | meaning
// IDLE  | waiting for start, in_ready_o high
// LOAD  | issuing row reads 0..SIZE-1 and capturing returned rows
// CALC  | computing column j, row i from j down to 0 (MAC steps, divide, write-back)
// OUT   | presenting column j until out_ready_i
module triang_mat_inv
  import triang_inv_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(SIZE)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [SIZE*2*WIDTH-1:0]   mat_row_i,
  input  logic                      mat_row_valid_i,
  input  logic [AW-1:0]             mat_row_addr_i,
  output logic [AW-1:0]             mat_row_addr_o,
  output logic                      mat_row_addr_valid_o,
  output logic [2*SIZE*WIDTH-1:0]   inv_col_o,
  output logic [AW-1:0]             inv_col_addr_o,
  output logic                      inv_col_valid_o,
  output logic                      in_ready_o,
  input  logic                      flush_i,
  input  logic                      start,
  input  logic                      out_ready_i,
  output logic                      busy_o
);

  localparam logic [1:0]  S_IDLE = ST_IDLE;
  localparam logic [1:0]  S_LOAD = ST_LOAD;
  localparam logic [1:0]  S_CALC = ST_CALC;
  localparam logic [1:0]  S_OUT  = ST_OUT;
  localparam logic [AW:0] N_ROWS = (AW+1)'(SIZE);
  localparam logic [AW:0] K_ONE  = (AW+1)'(1);
  localparam logic [AW:0] K_TWO  = (AW+1)'(2);
  localparam logic [AW-1:0] LAST_J = AW'(SIZE - 1);

  logic [1:0]    state_q;
  logic [AW:0]   issue_q, got_q;
  logic [AW-1:0] j_q, i_q;
  logic [AW:0]   k_q;
  logic          wb_q;

  cplx_t a_mem [SIZE][SIZE];
  cplx_t x_col [SIZE];

  logic [AW-1:0] k_idx;
  logic [AW:0]   i_p1;
  logic          mac_phase, first_step, fp_valid;
  cplx_t         acc_init, diag_c, fp_acc, fp_a, fp_b, fp_res;

  assign k_idx      = k_q[AW-1:0];
  assign i_p1       = {1'b0, i_q} + K_ONE;
  assign mac_phase  = (k_q <= {1'b0, j_q});
  assign first_step = (k_q == i_p1);
  assign acc_init   = (i_q == j_q) ? CPLX_ONE : CPLX_ZERO;
  // The accumulator carries -(sum of terms); the first step of each row seeds it.
  assign fp_acc     = first_step ? acc_init : fp_res;
  assign fp_a       = a_mem[i_q][k_idx];
  assign fp_b       = mac_phase ? x_col[k_idx] : diag_c;
  assign fp_valid   = (state_q == S_CALC) && !wb_q;

`ifdef TRIANG_INV_UNIT_DIAG_EN
  assign diag_c = CPLX_ONE;
`else
  assign diag_c = a_mem[i_q][i_q];
`endif

  cplx_fp_unit u_fp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .op_valid (fp_valid),
    .op_div   (!mac_phase),
    .acc      (fp_acc),
    .a        (fp_a),
    .b        (fp_b),
    .res      (fp_res)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      issue_q <= '0;
      got_q   <= '0;
      j_q     <= '0;
      i_q     <= '0;
      k_q     <= '0;
      wb_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      issue_q <= '0;
      got_q   <= '0;
      j_q     <= '0;
      i_q     <= '0;
      k_q     <= '0;
      wb_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            issue_q <= '0;
            got_q   <= '0;
          end
        end
        S_LOAD: begin
          if (issue_q != N_ROWS) issue_q <= issue_q + 1'b1;
          if (mat_row_valid_i) begin
            got_q <= got_q + 1'b1;
            if (got_q == N_ROWS - 1'b1) begin
              state_q <= S_CALC;
              j_q     <= '0;
              i_q     <= '0;
              k_q     <= K_ONE;
              wb_q    <= 1'b0;
            end
          end
        end
        S_CALC: begin
          if (wb_q) begin
            wb_q <= 1'b0;
            if (i_q == '0) begin
              state_q <= S_OUT;
            end else begin
              i_q <= i_q - 1'b1;
              k_q <= {1'b0, i_q};
            end
          end else if (mac_phase) begin
            k_q <= k_q + 1'b1;
          end else begin
            wb_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            if (j_q == LAST_J) begin
              state_q <= S_IDLE;
              j_q     <= '0;
            end else begin
              state_q <= S_CALC;
              j_q     <= j_q + 1'b1;
              i_q     <= j_q + 1'b1;
              k_q     <= {1'b0, j_q} + K_TWO;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; their contents are rewritten before use.
  always_ff @(posedge clk_i) begin
    if (state_q == S_LOAD && mat_row_valid_i) begin
      for (int c = 0; c < SIZE; c++) begin
        a_mem[mat_row_addr_i][c] <= mat_row_i[c*2*WIDTH +: 2*WIDTH];
      end
    end
    if (state_q == S_CALC && wb_q) begin
      x_col[i_q] <= fp_res;
    end
  end

  always_comb begin
    inv_col_o = '0;
    if (state_q == S_OUT) begin
      for (int r = 0; r < SIZE; r++) begin
        if (AW'(r) <= j_q) begin
          inv_col_o[2*r*WIDTH +: WIDTH]     = x_col[r].re;
          inv_col_o[(2*r+1)*WIDTH +: WIDTH] = x_col[r].im;
        end
      end
    end
  end

  assign in_ready_o           = (state_q == S_IDLE);
  assign busy_o               = (state_q != S_IDLE);
  assign mat_row_addr_valid_o = (state_q == S_LOAD) && (issue_q != N_ROWS);
  assign mat_row_addr_o       = mat_row_addr_valid_o ? issue_q[AW-1:0] : '0;
  assign inv_col_valid_o      = (state_q == S_OUT);
  assign inv_col_addr_o       = j_q;

endmodule

// File: tb/tb_triang_mat_inv.sv
// Scoreboard bench for triang_mat_inv at SIZE=4 with hand-computed inverses.
module tb_triang_mat_inv;

  localparam int SIZE = 4;
  localparam int AW   = 2;
  localparam int W    = 64;
  localparam int LAT  = 2;

  typedef struct packed {
    logic [AW-1:0]       addr;
    logic [2*SIZE*W-1:0] data;
  } exp_t;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [SIZE*2*W-1:0]   mat_row_i;
  logic                  mat_row_valid_i;
  logic [AW-1:0]         mat_row_addr_i;
  logic [AW-1:0]         mat_row_addr_o;
  logic                  mat_row_addr_valid_o;
  logic [2*SIZE*W-1:0]   inv_col_o;
  logic [AW-1:0]         inv_col_addr_o;
  logic                  inv_col_valid_o;
  logic                  in_ready_o;
  logic                  flush_i;
  logic                  start;
  logic                  out_ready_i;
  logic                  busy_o;

  int   total = 0;
  int   bad = 0;
  int   xfer_cnt = 0;
  real  a_re [SIZE][SIZE];
  real  a_im [SIZE][SIZE];
  real  e_re [SIZE][SIZE];
  real  e_im [SIZE][SIZE];
  exp_t exp_q [$];

  always #5 clk_i = ~clk_i;

  triang_mat_inv #(.SIZE(SIZE), .WIDTH(W), .AW(AW)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .mat_row_i            (mat_row_i),
    .mat_row_valid_i      (mat_row_valid_i),
    .mat_row_addr_i       (mat_row_addr_i),
    .mat_row_addr_o       (mat_row_addr_o),
    .mat_row_addr_valid_o (mat_row_addr_valid_o),
    .inv_col_o            (inv_col_o),
    .inv_col_addr_o       (inv_col_addr_o),
    .inv_col_valid_o      (inv_col_valid_o),
    .in_ready_o           (in_ready_o),
    .flush_i              (flush_i),
    .start                (start),
    .out_ready_i          (out_ready_i),
    .busy_o               (busy_o)
  );

  task automatic check_int(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic clear_mats();
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        a_re[r][c] = 0.0; a_im[r][c] = 0.0;
        e_re[r][c] = 0.0; e_im[r][c] = 0.0;
      end
    end
  endtask

  // Rows [1 2 0 0],[0 1 3 0],[0 0 1 0],[0 0 0 1] with junk below the diagonal.
  task automatic set_upper();
    clear_mats();
    for (int d = 0; d < SIZE; d++) begin
      a_re[d][d] = 1.0; e_re[d][d] = 1.0;
    end
    a_re[0][1] = 2.0; a_re[1][2] = 3.0;
    a_re[2][0] = 7.0; a_im[3][1] = -5.0;
    e_re[0][1] = -2.0; e_re[0][2] = 6.0; e_re[1][2] = -3.0;
  endtask

  task automatic push_exp(input int ncols);
    exp_t e;
    for (int j = 0; j < ncols; j++) begin
      e.addr = AW'(j);
      e.data = '0;
      for (int i = 0; i < SIZE; i++) begin
        e.data[2*i*W +: W]     = $realtobits(e_re[i][j]);
        e.data[(2*i+1)*W +: W] = $realtobits(e_im[i][j]);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic run(input string nm, input int ncols, input int stall_col, input int flush_col);
    int x0, stall_n, fl_w;
    bit done;
    push_exp(ncols);
    x0 = xfer_cnt; stall_n = 0; fl_w = 0; done = 1'b0;
    out_ready_i = 1'b1;
    start = 1'b1;
    @(posedge clk_i); #1;
    start = 1'b0;
    check_int({nm, "_busy"}, int'(busy_o), 1);
    check_int({nm, "_in_ready"}, int'(in_ready_o), 0);
    for (int c = 0; c < 3000 && !done; c++) begin
      if (stall_col >= 0 && inv_col_valid_o && int'(inv_col_addr_o) == stall_col && stall_n < 10) begin
        out_ready_i = 1'b0;
        stall_n++;
      end else begin
        out_ready_i = 1'b1;
      end
      @(posedge clk_i); #1;
      if (in_ready_o) begin
        done = 1'b1;
      end else if (flush_col >= 0 && (xfer_cnt - x0) > flush_col) begin
        fl_w++;
        if (fl_w == 4) begin
          flush_i = 1'b1;
          @(posedge clk_i); #1;
          flush_i = 1'b0;
          check_int({nm, "_fl_in_ready"}, int'(in_ready_o), 1);
          check_int({nm, "_fl_busy"}, int'(busy_o), 0);
          check_int({nm, "_fl_col_valid"}, int'(inv_col_valid_o), 0);
          check_int({nm, "_fl_addr_valid"}, int'(mat_row_addr_valid_o), 0);
          check_int({nm, "_fl_col_addr"}, int'(inv_col_addr_o), 0);
          total++;
          if (inv_col_o != '0) begin
            bad++;
            $display("FAIL %s_fl_col_data: got nonzero, want 0", nm);
          end
          done = 1'b1;
        end
      end
    end
    check_int({nm, "_finished"}, int'(done), 1);
    if (stall_col >= 0) check_int({nm, "_stalls"}, stall_n, 10);
    out_ready_i = 1'b1;
    repeat (30) @(posedge clk_i);
    #1;
    check_int({nm, "_cols"}, xfer_cnt - x0, ncols);
    check_int({nm, "_pending"}, exp_q.size(), 0);
    check_int({nm, "_end_in_ready"}, int'(in_ready_o), 1);
    check_int({nm, "_end_busy"}, int'(busy_o), 0);
    exp_q.delete();
  endtask

  // Row memory model: answers each read request LAT cycles later.
  initial begin : responder
    int q_addr [$];
    int q_due [$];
    int cyc;
    int r;
    cyc = 0;
    mat_row_valid_i = 1'b0;
    mat_row_addr_i  = '0;
    mat_row_i       = '0;
    forever begin
      @(posedge clk_i); #1;
      cyc++;
      if (mat_row_addr_valid_o) begin
        q_addr.push_back(int'(mat_row_addr_o));
        q_due.push_back(cyc + LAT);
      end
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        r = q_addr.pop_front();
        q_due.delete(0);
        mat_row_valid_i = 1'b1;
        mat_row_addr_i  = AW'(r);
        for (int c = 0; c < SIZE; c++) begin
          mat_row_i[c*2*W +: W]     = $realtobits(a_re[r][c]);
          mat_row_i[c*2*W + W +: W] = $realtobits(a_im[r][c]);
        end
      end else begin
        mat_row_valid_i = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t        e;
    logic [W-1:0] ar, er;
    forever begin
      @(negedge clk_i);
      if (inv_col_valid_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_col: got addr %0d, want no column", inv_col_addr_o);
        end else begin
          e = exp_q[0];
          check_int("col_addr", int'(inv_col_addr_o), int'(e.addr));
          for (int s = 0; s < 2*SIZE; s++) begin
            ar = inv_col_o[s*W +: W];
            er = e.data[s*W +: W];
            total++;
            if ($bitstoreal(ar) != $bitstoreal(er)) begin
              bad++;
              $display("FAIL col%0d_slot%0d: got %g, want %g", e.addr, s, $bitstoreal(ar), $bitstoreal(er));
            end
          end
          if (out_ready_i) begin
            exp_q.delete(0);
            xfer_cnt++;
          end
        end
      end
    end
  end

  initial begin : main
    start = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    rst_ni = 1'b0;
    clear_mats();
    repeat (3) @(posedge clk_i);
    #1;
    check_int("rst_in_ready", int'(in_ready_o), 1);
    check_int("rst_busy", int'(busy_o), 0);
    check_int("rst_addr_valid", int'(mat_row_addr_valid_o), 0);
    check_int("rst_col_valid", int'(inv_col_valid_o), 0);
    check_int("rst_row_addr", int'(mat_row_addr_o), 0);
    check_int("rst_col_addr", int'(inv_col_addr_o), 0);
    total++;
    if (inv_col_o != '0) begin
      bad++;
      $display("FAIL rst_col_data: got nonzero, want 0");
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    clear_mats();
    for (int d = 0; d < SIZE; d++) begin
      a_re[d][d] = 1.0; e_re[d][d] = 1.0;
    end
    run("ident", 4, -1, -1);

    clear_mats();
    a_re[0][0] = 2.0; a_re[1][1] = 4.0; a_re[2][2] = -1.0; a_re[3][3] = 0.5;
    e_re[0][0] = 0.5; e_re[1][1] = 0.25; e_re[2][2] = -1.0; e_re[3][3] = 2.0;
    run("diag", 4, -1, -1);

    set_upper();
    run("upper_stall", 4, 1, -1);

    clear_mats();
    for (int d = 0; d < SIZE; d++) begin
      a_im[d][d] = 1.0; e_im[d][d] = -1.0;
    end
    run("imag", 4, -1, -1);

    set_upper();
    run("flush", 3, -1, 2);

    // [1 j 0 0; 0 2 0 0; I] -> X[0][1] = -0.5j, X[1][1] = 0.5
    clear_mats();
    a_re[0][0] = 1.0; a_im[0][1] = 1.0; a_re[1][1] = 2.0; a_re[2][2] = 1.0; a_re[3][3] = 1.0;
    e_re[0][0] = 1.0; e_im[0][1] = -0.5; e_re[1][1] = 0.5; e_re[2][2] = 1.0; e_re[3][3] = 1.0;
    run("restart_cplx", 4, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
